// File: rtl/pio_pkg.sv
// Shared PIO definitions: request/completion encodings and responder states,
// also used by the root-port controller.
package pio_pkg;

    typedef enum logic [2:0] {
        REQ_MRD32 = 3'b000,
        REQ_MWR32 = 3'b001,
        REQ_MRD64 = 3'b010,
        REQ_MWR64 = 3'b011,
        REQ_IORD  = 3'b100,
        REQ_IOWR  = 3'b101
    } req_type_e;

    typedef enum logic {
        CPL_NODATA = 1'b0,
        CPL_DATA   = 1'b1
    } cpl_type_e;

    typedef enum logic [2:0] {
        CPL_SC = 3'b000,
        CPL_UR = 3'b001
    } cpl_status_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_READ_DATA,
        ST_CPL,
        ST_CPL_WAIT,
        ST_DROP
    } pio_state_e;

    function automatic logic is_read(input logic [2:0] t);
        return (t == REQ_MRD32) || (t == REQ_MRD64) || (t == REQ_IORD);
    endfunction

    function automatic logic is_write(input logic [2:0] t);
        return (t == REQ_MWR32) || (t == REQ_MWR64) || (t == REQ_IOWR);
    endfunction

    // Status counters stick at all-ones rather than wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/pio_bar_mem.sv
// Single-port DW storage behind the BAR aperture; synchronous read, no reset
// so it maps onto block RAM.
module pio_bar_mem #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/pio_target_responder.sv
// PIO target: decodes requests against BAR A, services reads/writes from the
// DW store and hands completions to the completion generator.
module pio_target_responder
    import pio_pkg::*;
#(
    parameter int          TCQ        = 1,
    parameter logic [31:0] BAR_A_BASE = 32'hFFFF_0000,
    parameter int          BAR_A_SIZE = 1024
) (
    input  logic        user_clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_type,
    input  logic [7:0]  req_tag,
    input  logic [63:0] req_addr,
    input  logic [31:0] req_data,
    output logic        cpl_type,
    output logic [7:0]  cpl_tag,
    output logic [31:0] cpl_data,
    output logic [2:0]  cpl_status,
    output logic        cpl_start,
    input  logic        cpl_done,
    output logic [15:0] wr_count,
    output logic [15:0] rd_count,
    output logic [15:0] err_count
);

    localparam int          AW      = $clog2(BAR_A_SIZE);
    localparam logic [32:0] BAR_END = {1'b0, BAR_A_BASE} + 33'(4 * BAR_A_SIZE);

    if (BAR_A_SIZE < 4 || BAR_A_SIZE > 4096 || (BAR_A_SIZE & (BAR_A_SIZE - 1)) != 0 || TCQ < 0)
    begin : g_bad_param
        $error("pio_target_responder: BAR_A_SIZE must be a power of two in 4..4096");
    end

    pio_state_e  state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic [2:0]  type_q, type_d;
    logic [7:0]  tag_q, tag_d;
    logic [31:0] data_q, data_d;
    logic [AW-1:0] idx_q, idx_d;
    logic        hit_q, hit_d;
    cpl_type_e   cpl_type_q, cpl_type_d;
    logic [7:0]  cpl_tag_q, cpl_tag_d;
    logic [31:0] cpl_data_q, cpl_data_d;
    cpl_status_e cpl_status_q, cpl_status_d;
    logic        cpl_start_q, cpl_start_d;
    logic [15:0] wr_count_q, wr_count_d;
    logic [15:0] rd_count_q, rd_count_d;
    logic [15:0] err_count_q, err_count_d;

    logic          req_hit;
    logic [AW-1:0] req_idx;
    logic          mem_we;
    logic [31:0]   mem_rdata;

    // Bit 32 of the compare keeps an aperture ending at 4 GB from wrapping.
    assign req_hit = (req_addr[63:32] == 32'h0)
                  && ({1'b0, req_addr[31:0]} >= {1'b0, BAR_A_BASE})
                  && ({1'b0, req_addr[31:0]} < BAR_END);
    assign req_idx = AW'((req_addr[31:0] - BAR_A_BASE) >> 2);

    always_comb begin
        state_d      = state_q;
        type_d       = type_q;
        tag_d        = tag_q;
        data_d       = data_q;
        idx_d        = idx_q;
        hit_d        = hit_q;
        cpl_type_d   = cpl_type_q;
        cpl_tag_d    = cpl_tag_q;
        cpl_data_d   = cpl_data_q;
        cpl_status_d = cpl_status_q;
        wr_count_d   = wr_count_q;
        rd_count_d   = rd_count_q;
        err_count_d  = err_count_q;
        mem_we       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    type_d = req_type;
                    tag_d  = req_tag;
                    data_d = req_data;
                    idx_d  = req_idx;
                    hit_d  = req_hit;
                    // Reads always pass through ST_READ so hit and miss share one decode point.
                    if (is_read(req_type)) begin
                        state_d = ST_READ;
                    end else if (is_write(req_type) && req_hit) begin
                        state_d = ST_WRITE;
                    end else if (req_type == REQ_IOWR) begin
                        state_d      = ST_CPL;
                        cpl_type_d   = CPL_NODATA;
                        cpl_tag_d    = req_tag;
                        cpl_data_d   = 32'h0;
                        cpl_status_d = CPL_UR;
                        err_count_d  = sat_inc(err_count_q);
                    end else begin
                        state_d = ST_DROP;
                    end
                end
            end
            ST_WRITE: begin
                mem_we     = 1'b1;
                wr_count_d = sat_inc(wr_count_q);
                if (type_q == REQ_IOWR) begin
                    state_d      = ST_CPL;
                    cpl_type_d   = CPL_NODATA;
                    cpl_tag_d    = tag_q;
                    cpl_data_d   = 32'h0;
                    cpl_status_d = CPL_SC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (hit_q) begin
                    state_d = ST_READ_DATA;
                end else begin
                    state_d      = ST_CPL;
                    cpl_type_d   = CPL_NODATA;
                    cpl_tag_d    = tag_q;
                    cpl_data_d   = 32'h0;
                    cpl_status_d = CPL_UR;
                    err_count_d  = sat_inc(err_count_q);
                end
            end
            ST_READ_DATA: begin
                state_d      = ST_CPL;
                cpl_type_d   = CPL_DATA;
                cpl_tag_d    = tag_q;
                cpl_data_d   = mem_rdata;
                cpl_status_d = CPL_SC;
                rd_count_d   = sat_inc(rd_count_q);
            end
            ST_CPL:      state_d = ST_CPL_WAIT;
            ST_CPL_WAIT: if (cpl_done) state_d = ST_IDLE;
            ST_DROP: begin
                err_count_d = sat_inc(err_count_q);
                state_d     = ST_IDLE;
            end
            default:     state_d = ST_IDLE;
        endcase

        req_ready_d = (state_d == ST_IDLE);
        cpl_start_d = (state_d == ST_CPL);
    end

    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b0;
            type_q       <= 3'b0;
            tag_q        <= 8'h0;
            data_q       <= 32'h0;
            idx_q        <= '0;
            hit_q        <= 1'b0;
            cpl_type_q   <= CPL_NODATA;
            cpl_tag_q    <= 8'h0;
            cpl_data_q   <= 32'h0;
            cpl_status_q <= CPL_SC;
            cpl_start_q  <= 1'b0;
            wr_count_q   <= 16'h0;
            rd_count_q   <= 16'h0;
            err_count_q  <= 16'h0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            type_q       <= type_d;
            tag_q        <= tag_d;
            data_q       <= data_d;
            idx_q        <= idx_d;
            hit_q        <= hit_d;
            cpl_type_q   <= cpl_type_d;
            cpl_tag_q    <= cpl_tag_d;
            cpl_data_q   <= cpl_data_d;
            cpl_status_q <= cpl_status_d;
            cpl_start_q  <= cpl_start_d;
            wr_count_q   <= wr_count_d;
            rd_count_q   <= rd_count_d;
            err_count_q  <= err_count_d;
        end
    end

    pio_bar_mem #(
        .DEPTH (BAR_A_SIZE),
        .AW    (AW)
    ) u_mem (
        .clk   (user_clk),
        .we    (mem_we),
        .addr  (idx_q),
        .wdata (data_q),
        .rdata (mem_rdata)
    );

    assign req_ready  = req_ready_q;
    assign cpl_type   = cpl_type_q;
    assign cpl_tag    = cpl_tag_q;
    assign cpl_data   = cpl_data_q;
    assign cpl_status = cpl_status_q;
    assign cpl_start  = cpl_start_q;
    assign wr_count   = wr_count_q;
    assign rd_count   = rd_count_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_pio_target_responder.sv
// Directed bench for pio_target_responder: hand-computed completions, latencies,
// counters, aperture edges, completion hold-off and mid-transaction reset.
module tb_pio_target_responder;

    logic        user_clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_type;
    logic [7:0]  req_tag;
    logic [63:0] req_addr;
    logic [31:0] req_data;
    logic        cpl_type;
    logic [7:0]  cpl_tag;
    logic [31:0] cpl_data;
    logic [2:0]  cpl_status;
    logic        cpl_start;
    logic        cpl_done;
    logic [15:0] wr_count;
    logic [15:0] rd_count;
    logic [15:0] err_count;

    int vectors     = 0;
    int miscompares = 0;
    int start_count = 0;

    pio_target_responder #(
        .TCQ        (1),
        .BAR_A_BASE (32'hFFFF_0000),
        .BAR_A_SIZE (1024)
    ) dut (
        .user_clk   (user_clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_type   (req_type),
        .req_tag    (req_tag),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .cpl_type   (cpl_type),
        .cpl_tag    (cpl_tag),
        .cpl_data   (cpl_data),
        .cpl_status (cpl_status),
        .cpl_start  (cpl_start),
        .cpl_done   (cpl_done),
        .wr_count   (wr_count),
        .rd_count   (rd_count),
        .err_count  (err_count)
    );

    always #5 user_clk = ~user_clk;

    always @(posedge user_clk) begin
        if (cpl_start === 1'b1) start_count++;
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Waits for req_ready, presents one request for a single accepting edge,
    // and returns on the negedge right after acceptance.
    task automatic applyStimulus(input logic [2:0] t, input logic [7:0] tag,
                                 input logic [63:0] addr, input logic [31:0] data);
        int waited = 0;
        @(negedge user_clk);
        while (req_ready !== 1'b1 && waited < 50) begin
            @(negedge user_clk);
            waited++;
        end
        if (waited >= 50) checkOutput("ready_timeout", {63'h0, req_ready}, 64'h1);
        req_type  = t;
        req_tag   = tag;
        req_addr  = addr;
        req_data  = data;
        req_valid = 1'b1;
        @(posedge user_clk);
        @(negedge user_clk);
        req_valid = 1'b0;
    endtask

    // Latency counts accepting edge to the edge that first samples cpl_start high.
    task automatic waitCpl(output int lat);
        lat = 0;
        for (int j = 0; j < 40; j++) begin
            if (cpl_start === 1'b1) begin
                lat = j + 1;
                break;
            end
            @(negedge user_clk);
        end
    endtask

    task automatic finishCpl(input string name);
        @(negedge user_clk);
        checkOutput({name, "_start_pulse"}, {63'h0, cpl_start}, 64'h0);
        cpl_done = 1'b1;
        @(negedge user_clk);
        cpl_done = 1'b0;
    endtask

    task automatic readCheck(input string name, input logic [2:0] t, input logic [7:0] tag,
                             input logic [63:0] addr, input logic [31:0] wdata, input int exp_lat,
                             input logic exp_type, input logic [31:0] exp_data,
                             input logic [2:0] exp_status);
        int lat;
        applyStimulus(t, tag, addr, wdata);
        waitCpl(lat);
        checkOutput({name, "_latency"}, 64'(lat), 64'(exp_lat));
        checkOutput({name, "_type"},    {63'h0, cpl_type}, {63'h0, exp_type});
        checkOutput({name, "_tag"},     {56'h0, cpl_tag}, {56'h0, tag});
        checkOutput({name, "_data"},    {32'h0, cpl_data}, {32'h0, exp_data});
        checkOutput({name, "_status"},  {61'h0, cpl_status}, {61'h0, exp_status});
        finishCpl(name);
    endtask

    task automatic postedCheck(input string name, input logic [2:0] t,
                               input logic [63:0] addr, input logic [31:0] data);
        int s0 = start_count;
        applyStimulus(t, 8'h00, addr, data);
        checkOutput({name, "_ready_busy"}, {63'h0, req_ready}, 64'h0);
        @(negedge user_clk);
        checkOutput({name, "_ready_back"}, {63'h0, req_ready}, 64'h1);
        checkOutput({name, "_no_cpl"}, 64'(start_count - s0), 64'h0);
    endtask

    initial begin
        int lat;
        int s0;
        logic stable;
        logic [31:0] snap_data;
        logic [7:0]  snap_tag;
        logic        snap_type;
        logic [2:0]  snap_status;

        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_type  = 3'b000;
        req_tag   = 8'h00;
        req_addr  = 64'h0;
        req_data  = 32'h0;
        cpl_done  = 1'b0;

        repeat (3) @(negedge user_clk);
        checkOutput("rst_ready", {63'h0, req_ready}, 64'h0);
        checkOutput("rst_start", {63'h0, cpl_start}, 64'h0);
        checkOutput("rst_counts", {16'h0, wr_count, rd_count, err_count}, 64'h0);
        reset_n = 1'b1;
        @(negedge user_clk);
        checkOutput("rst_release_ready", {63'h0, req_ready}, 64'h1);

        $display("[TB] basic write/read");
        postedCheck("mwr_hit", 3'b001, 64'h0000_0000_FFFF_0010, 32'h1234_5678);
        checkOutput("mwr_wr_count", {48'h0, wr_count}, 64'd1);
        readCheck("mrd_hit", 3'b000, 8'h05, 64'h0000_0000_FFFF_0010, 32'h0, 3, 1'b1, 32'h1234_5678, 3'b000);
        checkOutput("mrd_rd_count", {48'h0, rd_count}, 64'd1);

        readCheck("mrd_miss", 3'b000, 8'h22, 64'h0000_0000_0000_1000, 32'h0, 2, 1'b0, 32'h0, 3'b001);
        checkOutput("mrd_miss_err", {48'h0, err_count}, 64'd1);

        $display("[TB] IO write/read");
        s0 = start_count;
        readCheck("iowr_hit", 3'b101, 8'h31, 64'h0000_0000_FFFF_0020, 32'hDEAD_BEEF, 2, 1'b0, 32'h0, 3'b000);
        checkOutput("iowr_one_start", 64'(start_count - s0), 64'd1);
        checkOutput("iowr_wr_count", {48'h0, wr_count}, 64'd2);
        readCheck("iord_hit", 3'b100, 8'h32, 64'h0000_0000_FFFF_0020, 32'h0, 3, 1'b1, 32'hDEAD_BEEF, 3'b000);

        $display("[TB] misses and drops");
        readCheck("mrd64_hi", 3'b010, 8'h40, 64'h0000_0001_FFFF_0010, 32'h0, 2, 1'b0, 32'h0, 3'b001);
        checkOutput("mrd64_err", {48'h0, err_count}, 64'd2);
        postedCheck("mwr_miss", 3'b001, 64'h0000_0000_0000_2000, 32'hCAFE_F00D);
        checkOutput("mwr_miss_err", {48'h0, err_count}, 64'd3);
        checkOutput("mwr_miss_wr", {48'h0, wr_count}, 64'd2);

        $display("[TB] aperture edges");
        postedCheck("mwr_top", 3'b001, 64'h0000_0000_FFFF_0FFC, 32'hA5A5_0FFC);
        readCheck("mrd_top", 3'b000, 8'h41, 64'h0000_0000_FFFF_0FFC, 32'h0, 3, 1'b1, 32'hA5A5_0FFC, 3'b000);
        readCheck("mrd_past_top", 3'b000, 8'h42, 64'h0000_0000_FFFF_1000, 32'h0, 2, 1'b0, 32'h0, 3'b001);
        readCheck("mrd_below_base", 3'b000, 8'h43, 64'h0000_0000_FFFE_FFFC, 32'h0, 2, 1'b0, 32'h0, 3'b001);
        postedCheck("reserved", 3'b110, 64'h0000_0000_FFFF_0010, 32'h0);
        checkOutput("edge_counts", {16'h0, wr_count, rd_count, err_count}, {16'h0, 16'd3, 16'd3, 16'd6});

        $display("[TB] completion hold-off");
        applyStimulus(3'b000, 8'h77, 64'h0000_0000_FFFF_0010, 32'h0);
        cpl_done = 1'b1;
        @(negedge user_clk);
        cpl_done = 1'b0;
        waitCpl(lat);
        checkOutput("holdoff_latency", 64'(lat), 64'd2);
        snap_data   = cpl_data;
        snap_tag    = cpl_tag;
        snap_type   = cpl_type;
        snap_status = cpl_status;
        checkOutput("holdoff_data", {32'h0, cpl_data}, 64'h1234_5678);
        checkOutput("holdoff_tag", {56'h0, cpl_tag}, 64'h77);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge user_clk);
            if (req_ready !== 1'b0 || cpl_start !== 1'b0 || cpl_data !== snap_data ||
                cpl_tag !== snap_tag || cpl_type !== snap_type || cpl_status !== snap_status)
                stable = 1'b0;
        end
        checkOutput("holdoff_stable", {63'h0, stable}, 64'h1);
        cpl_done = 1'b1;
        @(negedge user_clk);
        cpl_done = 1'b0;
        checkOutput("holdoff_release", {63'h0, req_ready}, 64'h1);
        checkOutput("holdoff_rd_count", {48'h0, rd_count}, 64'd4);

        $display("[TB] reset during completion wait");
        applyStimulus(3'b000, 8'h99, 64'h0000_0000_FFFF_0010, 32'h0);
        waitCpl(lat);
        @(negedge user_clk);
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_ready", {63'h0, req_ready}, 64'h0);
        checkOutput("midrst_cpl", {22'h0, cpl_start, cpl_type, cpl_tag, cpl_data}, 64'h0);
        checkOutput("midrst_status", {61'h0, cpl_status}, 64'h0);
        checkOutput("midrst_counts", {16'h0, wr_count, rd_count, err_count}, 64'h0);
        s0 = start_count;
        @(negedge user_clk);
        reset_n = 1'b1;
        @(negedge user_clk);
        checkOutput("midrst_ready_back", {63'h0, req_ready}, 64'h1);
        repeat (5) @(negedge user_clk);
        checkOutput("midrst_no_start", 64'(start_count - s0), 64'h0);
        readCheck("post_rst_rd", 3'b000, 8'h5A, 64'h0000_0000_FFFF_0010, 32'h0, 3, 1'b1, 32'h1234_5678, 3'b000);
        checkOutput("post_rst_rd_count", {48'h0, rd_count}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pio_target_responder.md
PIO_TARGET_RESPONDER -- requirements
Module: pio_target_responder

Interface
REQ-001 SHALL have parameter TCQ, default 1, simulation-only clock-to-Q delay.
REQ-002 SHALL have parameter BAR_A_BASE [31:0], default 32'hFFFF_0000, byte base address of the BAR aperture.
REQ-003 SHALL have parameter BAR_A_SIZE, default 1024, aperture size in DW; must be a power of two, from 4 to 4096.
REQ-004 SHALL have port user_clk, input, 1 bit: the single clock.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have ports req_valid / req_ready, input / output, 1 bit each: decoded-request handshake from the RX decoder.
REQ-007 SHALL have port req_type, input, 3 bits: 000 MemRd32, 001 MemWr32, 010 MemRd64, 011 MemWr64, 100 IORd, 101 IOWr, 110/111 reserved.
REQ-008 SHALL have ports req_tag [7:0], req_addr [63:0] and req_data [31:0], all inputs, carrying the request tag, byte address and write DW.
REQ-009 SHALL have outputs cpl_type (1 bit: 0 Cpl, 1 CplD), cpl_tag [7:0], cpl_data [31:0] and cpl_status [2:0] (000 SC, 001 UR) to the completion generator.
REQ-010 SHALL have output cpl_start (1 bit) and input cpl_done (1 bit): completion launch pulse and transmit-complete acknowledgement.
REQ-011 SHALL have outputs wr_count [15:0], rd_count [15:0] and err_count [15:0] as status counters.

Function
REQ-012 SHALL use the states ST_IDLE, ST_WRITE, ST_READ, ST_READ_DATA, ST_CPL, ST_CPL_WAIT and ST_DROP.
REQ-013 SHALL accept a request only when req_valid && req_ready; req_ready SHALL be 1 only in ST_IDLE.
REQ-014 SHALL register type, tag, address and data on acceptance.
REQ-015 SHALL decode a hit as addr[63:32]==0 and BAR_A_BASE <= addr[31:0] < BAR_A_BASE + 4*BAR_A_SIZE; DW index = (addr[31:0] - BAR_A_BASE) >> 2; addr[1:0] is ignored.
REQ-016 SHALL, on a write hit (001/011/101), go to ST_WRITE, store req_data to the index in one cycle, and increment wr_count.
REQ-017 SHALL, after ST_WRITE, go to ST_CPL for IOWr (Cpl, SC, no data) and to ST_IDLE for MemWr, since memory writes are posted.
REQ-018 SHALL, on a read hit (000/010/100), take ST_READ then ST_READ_DATA (synchronous read, 1-cycle latency), latch cpl_data, increment rd_count, and go to ST_CPL with CplD/SC.
REQ-019 SHALL, on a read or IOWr miss, go to ST_CPL with Cpl/UR and cpl_data=0, and increment err_count.
REQ-020 SHALL, on a MemWr miss or a reserved type, go to ST_DROP for one cycle, increment err_count, then return to ST_IDLE with no completion.
REQ-021 SHALL, in ST_CPL, drive cpl_type/tag/data/status and pulse cpl_start for exactly one cycle, then move to ST_CPL_WAIT.
REQ-022 SHALL hold cpl_* stable in ST_CPL_WAIT until cpl_done, then return to ST_IDLE; no new request is accepted in the meantime.
REQ-023 SHALL set cpl_tag to the accepted req_tag exactly.
REQ-024 SHALL give a minimum accept-to-cpl_start latency of 3 cycles for a read hit and 2 cycles for a read miss; a posted write SHALL be back in ST_IDLE 2 cycles after acceptance.
REQ-025 SHALL saturate all counters at 16'hFFFF (no wrap).
REQ-026 SHALL ignore a cpl_done that arrives outside ST_CPL_WAIT.

Reset
REQ-027 SHALL, on reset_n low, immediately force ST_IDLE, req_ready=0, cpl_start=0, cpl_type=0, cpl_tag=0, cpl_data=0, cpl_status=0 and all counters to 0.
REQ-028 SHALL not reset memory contents; after reset, reads of unwritten locations return an undefined value.
REQ-029 SHALL abandon any transaction in progress when reset is asserted mid-operation, with no cpl_start after release until a new request is accepted; req_ready SHALL rise on the first clock edge after reset_n is released.

Structure
REQ-030 SHALL take the req_type, cpl_type and cpl_status encodings and the state encodings from a shared package (pio_pkg) used by the root-port controller.
REQ-031 SHALL implement the DW storage as sub-module pio_bar_mem: single-port, synchronous read, write-enable, depth BAR_A_SIZE.

Verification
REQ-032 SHALL cover: MemWr32 to addr 0xFFFF_0010 with data 0x1234_5678, then MemRd32 tag 0x05 to the same address -> CplD, tag 0x05, data 0x1234_5678, SC, with wr_count=1 and rd_count=1.
REQ-033 SHALL cover: MemRd32 to 0x0000_1000 (miss), tag 0x22 -> Cpl, UR, data 0, err_count=1.
REQ-034 SHALL cover: IOWr hit, data 0xDEAD_BEEF -> Cpl, SC, one cpl_start; a following IORd returns 0xDEAD_BEEF.
REQ-035 SHALL cover: MemRd64 with addr[63:32]=1 -> UR completion; MemWr32 miss -> no cpl_start, err_count incremented, req_ready back to 1 after 2 cycles.
REQ-036 SHALL cover: cpl_done held off for 20 cycles -> req_ready stays 0 and cpl_* stay stable; reset_n pulsed during ST_CPL_WAIT -> all outputs return to reset values and there is no spurious cpl_start.
REQ-037 SHALL cover: top-of-aperture boundary addr 0xFFFF_0FFC (hit) versus 0xFFFF_1000 (miss, for BAR_A_SIZE=1024).
